// File: rtl/mac_out_serializer.sv
// MAC return-path serializer: splits one packed MAC result into
// MIN_WIDTH beats (LSB first) over a valid/ready stream.
module mac_out_serializer #(
   parameter int MAC_CONF_WIDTH = 3,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [MAC_INT_WIDTH-1:0]  in_data,
   input  logic [MAC_CONF_WIDTH-1:0] in_cfg,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [MAC_MIN_WIDTH-1:0]  out_data,
   output logic [2:0]                out_idx,
   output logic                      out_last,
   output logic                      drop
);

   localparam logic [1:0] CFG_SINGLE = 2'b00;
   localparam logic [1:0] CFG_DUAL   = 2'b01;
   localparam logic [1:0] CFG_QUAD   = 2'b10;

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   state_e                   state_q, state_d;
   logic [MAC_INT_WIDTH-1:0] shift_q, shift_d;
   logic [2:0]               nbeats_q, nbeats_d;
   logic [2:0]               idx_q, idx_d;
   logic                     drop_q, drop_d;

   logic       sending;
   logic       last;
   logic       fire;
   logic       accept;
   logic       cfg_ok;
   logic [2:0] cfg_nb;
   logic       cfg_unused;

   assign cfg_unused = ^in_cfg[MAC_CONF_WIDTH-1:2];

   assign sending   = (state_q == SEND);
   assign last      = sending && (idx_q == nbeats_q - 3'd1);
   assign in_ready  = en && (!sending || (out_ready && last));
   assign fire      = en && sending && out_ready;
   assign accept    = in_valid && in_ready;

   assign out_valid = sending;
   assign out_data  = shift_q[MAC_MIN_WIDTH-1:0];
   assign out_idx   = idx_q;
   assign out_last  = last;
   assign drop      = drop_q;

   always_comb begin
      cfg_ok = 1'b1;
      cfg_nb = 3'd2;
      unique case (in_cfg[1:0])
         CFG_SINGLE: cfg_nb = 3'd2;
         CFG_DUAL:   cfg_nb = 3'd3;
         CFG_QUAD:   cfg_nb = 3'd5;
         default:    cfg_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      nbeats_d = nbeats_q;
      idx_d    = idx_q;
      drop_d   = 1'b0;

      if (fire) begin
         if (!last) begin
            shift_d = shift_q >> MAC_MIN_WIDTH;
            idx_d   = idx_q + 3'd1;
         end else begin
            state_d = IDLE;
         end
      end

      // a word accepted on the last beat overrides the return to IDLE
      if (accept) begin
         if (cfg_ok) begin
            shift_d  = in_data;
            nbeats_d = cfg_nb;
            idx_d    = 3'd0;
            state_d  = SEND;
         end else begin
            drop_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         nbeats_q <= 3'd0;
         idx_q    <= 3'd0;
         drop_q   <= 1'b0;
      end else if (en) begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         nbeats_q <= nbeats_d;
         idx_q    <= idx_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_mac_out_serializer.sv
// Directed bench for mac_out_serializer: single, quad with stalls,
// back-to-back, unsupported cfg, reset and enable freeze.
module tb_mac_out_serializer;

   localparam logic [2:0] SGL = 3'b000;
   localparam logic [2:0] DUL = 3'b001;
   localparam logic [2:0] QAD = 3'b010;
   localparam logic [2:0] BAD = 3'b011;

   logic        clk;
   logic        rst;
   logic        en;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] in_data;
   logic [2:0]  in_cfg;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        drop;

   int total = 0;
   int bad   = 0;

   mac_out_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cfg    (in_cfg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [7:0] d,
                       input logic [2:0] i, input logic l);
      chk({tag, "_v"}, 64'(out_valid), 64'd1);
      chk({tag, "_d"}, 64'(out_data), 64'(d));
      chk({tag, "_i"}, 64'(out_idx), 64'(i));
      chk({tag, "_l"}, 64'(out_last), 64'(l));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q_exp [5];

   initial begin
      clk       = 1'b0;
      rst       = 1'b0;
      en        = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_cfg    = SGL;
      out_ready = 1'b0;

      @(negedge clk);
      chk("rst_v", 64'(out_valid), 64'd0);
      chk("rst_d", 64'(out_data), 64'd0);
      chk("rst_i", 64'(out_idx), 64'd0);
      chk("rst_l", 64'(out_last), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
      chk("rst_inrdy", 64'(in_ready), 64'd0);
      cyc();
      rst = 1'b1;
      en  = 1'b1;

      // single word
      in_valid  = 1'b1;
      in_data   = 40'h00_0000_BEEF;
      in_cfg    = SGL;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t1_inrdy", 64'(in_ready), 64'd1);
      chk("t1_idle_v", 64'(out_valid), 64'd0);
      cyc();
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      beat("t1_b0", 8'hEF, 3'd0, 1'b0);
      chk("t1_rdy0", 64'(in_ready), 64'd0);
      cyc();
      @(negedge clk);
      beat("t1_b1", 8'hBE, 3'd1, 1'b1);
      chk("t1_rdy1", 64'(in_ready), 64'd1);
      cyc();
      @(negedge clk);
      chk("t1_end_v", 64'(out_valid), 64'd0);

      // quad with alternating backpressure
      q_exp = '{8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
      cyc();
      in_valid = 1'b1;
      in_data  = 40'h12_3456_789A;
      in_cfg   = QAD;
      cyc();
      in_valid = 1'b0;
      for (int b = 0; b < 5; b++) begin
         out_ready = 1'b0;
         @(negedge clk);
         beat($sformatf("t2_s%0d", b), q_exp[b], 3'(b), b == 4);
         cyc();
         out_ready = 1'b1;
         @(negedge clk);
         beat($sformatf("t2_h%0d", b), q_exp[b], 3'(b), b == 4);
         cyc();
      end
      @(negedge clk);
      chk("t2_end_v", 64'(out_valid), 64'd0);

      // back-to-back dual then single
      cyc();
      in_valid = 1'b1;
      in_data  = 40'h00_00AB_CDEF;
      in_cfg   = DUL;
      cyc();
      in_data  = 40'hFF_FFFF_1234;
      in_cfg   = SGL;
      @(negedge clk);
      beat("t3_b0", 8'hEF, 3'd0, 1'b0);
      chk("t3_rdy0", 64'(in_ready), 64'd0);
      cyc();
      @(negedge clk);
      beat("t3_b1", 8'hCD, 3'd1, 1'b0);
      cyc();
      @(negedge clk);
      beat("t3_b2", 8'hAB, 3'd2, 1'b1);
      chk("t3_rdy2", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      beat("t3_b3", 8'h34, 3'd0, 1'b0);
      cyc();
      @(negedge clk);
      beat("t3_b4", 8'h12, 3'd1, 1'b1);
      cyc();
      @(negedge clk);
      chk("t3_end_v", 64'(out_valid), 64'd0);

      // unsupported cfg from IDLE, then a normal word
      cyc();
      in_valid = 1'b1;
      in_data  = 40'h00_0000_CAFE;
      in_cfg   = BAD;
      @(negedge clk);
      chk("t4_inrdy", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_drop", 64'(drop), 64'd1);
      chk("t4_v", 64'(out_valid), 64'd0);
      cyc();
      @(negedge clk);
      chk("t4_drop_off", 64'(drop), 64'd0);
      chk("t4_v2", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      in_data  = 40'h00_0000_5AA5;
      in_cfg   = SGL;
      cyc();
      in_cfg   = BAD;
      in_data  = 40'h00_0000_0F0F;
      @(negedge clk);
      beat("t4_b0", 8'hA5, 3'd0, 1'b0);
      chk("t4_drop0", 64'(drop), 64'd0);
      cyc();
      @(negedge clk);
      beat("t4_b1", 8'h5A, 3'd1, 1'b1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_lastbad_drop", 64'(drop), 64'd1);
      chk("t4_lastbad_v", 64'(out_valid), 64'd0);
      cyc();
      @(negedge clk);
      chk("t4_lastbad_off", 64'(drop), 64'd0);

      // reset mid-word
      cyc();
      in_valid = 1'b1;
      in_data  = 40'h11_2233_4455;
      in_cfg   = QAD;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      beat("t5_b0", 8'h55, 3'd0, 1'b0);
      cyc();
      @(negedge clk);
      beat("t5_b1", 8'h44, 3'd1, 1'b0);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_rst_v", 64'(out_valid), 64'd0);
      chk("t5_rst_d", 64'(out_data), 64'd0);
      chk("t5_rst_i", 64'(out_idx), 64'd0);
      chk("t5_rst_l", 64'(out_last), 64'd0);
      chk("t5_rst_drop", 64'(drop), 64'd0);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_noresume_v", 64'(out_valid), 64'd0);
      chk("t5_noresume_i", 64'(out_idx), 64'd0);

      // enable freeze mid-word
      cyc();
      in_valid = 1'b1;
      in_data  = 40'h99_8877_6655;
      in_cfg   = QAD;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      beat("t6_b0", 8'h55, 3'd0, 1'b0);
      cyc();
      @(negedge clk);
      beat("t6_b1", 8'h66, 3'd1, 1'b0);
      en = 1'b0;
      cyc();
      @(negedge clk);
      beat("t6_f0", 8'h66, 3'd1, 1'b0);
      chk("t6_f_rdy", 64'(in_ready), 64'd0);
      cyc();
      @(negedge clk);
      beat("t6_f1", 8'h66, 3'd1, 1'b0);
      en = 1'b1;
      cyc();
      @(negedge clk);
      beat("t6_b2", 8'h77, 3'd2, 1'b0);
      cyc();
      @(negedge clk);
      beat("t6_b3", 8'h88, 3'd3, 1'b0);
      cyc();
      @(negedge clk);
      beat("t6_b4", 8'h99, 3'd4, 1'b1);
      cyc();
      @(negedge clk);
      chk("t6_end_v", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
